// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, Zicsr funct3 encodings and the
// read-modify-write operator used for the writable CSRs.
package csr_pkg;

  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

  // New CSR value from the old value and the operand; unknown ops leave it unchanged.
  function automatic logic [31:0] csr_alu(input csr_op_e op,
                                          input logic [31:0] old,
                                          input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_RW, CSR_RWI: res = src;
      CSR_RS, CSR_RSI: res = old | src;
      CSR_RC, CSR_RCI: res = old & ~src;
      default:         res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_cycle.sv
// 64-bit free-running cycle counter (mcycle), exported as two 32-bit halves.
module csr_cycle #(
  parameter logic [63:0] CYCLE_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] cycle_lo,
  output logic [31:0] cycle_hi
);

  logic [63:0] mcycle_r;

  // Count every clock, stalls and bubbles included; all-ones wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r <= CYCLE_RST;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  assign cycle_lo = mcycle_r[31:0];
  assign cycle_hi = mcycle_r[63:32];

endmodule

// File: rtl/csr_ctrl.sv
// Zicsr control for EX: decodes CSR ops, owns mscratch, reads mcycle and the
// external instret counter, and registers the old CSR value into EX/MEM.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MSCRATCH_RST = 32'h0,
  parameter logic [63:0] CYCLE_RST    = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic        mul_stall,
  input  logic        csr_en,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_rs1_idx,
  input  logic [31:0] csr_rs1_data,
  input  logic [31:0] inst_cnt_data,
  output logic        inst_nop,
  output logic        inst_r_en,
  output logic        inst_r_pos,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  output logic        csr_illegal
);

  logic [31:0] cycle_lo_s;
  logic [31:0] cycle_hi_s;
  logic [31:0] mscratch_r;
  logic [31:0] old_s;
  logic [31:0] src_s;
  logic        live_s;
  logic        access_s;
  logic        hit_s;
  logic        instret_s;
  logic        scratch_s;
  logic        op_ok_s;
  logic        wr_req_s;
  logic        illegal_s;
  logic        commit_s;

  csr_cycle #(.CYCLE_RST(CYCLE_RST)) u_cycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .cycle_lo (cycle_lo_s),
    .cycle_hi (cycle_hi_s)
  );

  assign live_s   = ex_valid & ~flush;
  assign access_s = csr_en & live_s;
  assign src_s    = csr_funct3[2] ? {27'd0, csr_rs1_idx} : csr_rs1_data;

  // Address decode and read mux; the value seen is the state before this edge.
  always_comb begin
    old_s     = 32'h0;
    hit_s     = 1'b0;
    instret_s = 1'b0;
    scratch_s = 1'b0;
    case (csr_addr)
      CSR_CYCLE, CSR_MCYCLE: begin
        old_s = cycle_lo_s;
        hit_s = 1'b1;
      end
      CSR_CYCLEH, CSR_MCYCLEH: begin
        old_s = cycle_hi_s;
        hit_s = 1'b1;
      end
      CSR_INSTRET, CSR_MINSTRET, CSR_INSTRETH, CSR_MINSTRETH: begin
        old_s     = inst_cnt_data;
        hit_s     = 1'b1;
        instret_s = 1'b1;
      end
      CSR_MSCRATCH: begin
        old_s     = mscratch_r;
        hit_s     = 1'b1;
        scratch_s = 1'b1;
      end
      default: begin
        old_s = 32'h0;
        hit_s = 1'b0;
      end
    endcase
  end

  // funct3 decode: set/clear with a zero source is a pure read.
  always_comb begin
    op_ok_s  = 1'b1;
    wr_req_s = 1'b0;
    case (csr_funct3)
      CSR_RW, CSR_RWI: wr_req_s = 1'b1;
      CSR_RS, CSR_RC, CSR_RSI, CSR_RCI: wr_req_s = (csr_rs1_idx != 5'd0);
      default: op_ok_s = 1'b0;
    endcase
  end

  assign illegal_s  = ~op_ok_s | ~hit_s | (wr_req_s & ~scratch_s);
  assign commit_s   = access_s & ~mul_stall & ~illegal_s;

  assign inst_nop   = live_s;
  assign inst_r_en  = access_s & instret_s;
  assign inst_r_pos = csr_addr[7];

  // mscratch is the only writable CSR; it updates on the committing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mscratch_r <= MSCRATCH_RST;
    end else if (commit_s & wr_req_s & scratch_s) begin
      mscratch_r <= csr_alu(csr_op_e'(csr_funct3), mscratch_r, src_s);
    end
  end

  // EX/MEM result register: flush clears, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata   <= 32'h0;
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else if (flush) begin
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else if (!mul_stall) begin
      if (commit_s) begin
        csr_rdata  <= old_s;
        csr_rvalid <= 1'b1;
      end else begin
        csr_rvalid <= 1'b0;
      end
      csr_illegal <= access_s & illegal_s;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl. Two instances share all inputs: one with
// default reset values, one with mcycle near wrap and a non-zero mscratch reset.
module tb_csr_ctrl;

  localparam logic [31:0] SCR_RST1 = 32'h1234_5678;
  localparam logic [63:0] CYC_RST1 = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, flush = 1'b0, mul_stall = 1'b0, csr_en = 1'b0;
  logic [2:0]  csr_funct3 = 3'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [4:0]  csr_rs1_idx = 5'd0;
  logic [31:0] csr_rs1_data = 32'd0, inst_cnt_data = 32'd0;

  logic        o_nop [2];
  logic        o_ren [2];
  logic        o_pos [2];
  logic [31:0] o_rdata [2];
  logic        o_rvalid [2];
  logic        o_ill [2];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [63:0] m_cyc;
  logic [31:0] m_scr [2];
  logic [31:0] m_rd [2];
  logic        m_rv [2];
  logic        m_il [2];
  logic [11:0] addr_tbl [10];

  always #5 clk = ~clk;

  csr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush), .mul_stall(mul_stall),
    .csr_en(csr_en), .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_rs1_idx(csr_rs1_idx),
    .csr_rs1_data(csr_rs1_data), .inst_cnt_data(inst_cnt_data),
    .inst_nop(o_nop[0]), .inst_r_en(o_ren[0]), .inst_r_pos(o_pos[0]),
    .csr_rdata(o_rdata[0]), .csr_rvalid(o_rvalid[0]), .csr_illegal(o_ill[0])
  );

  csr_ctrl #(.MSCRATCH_RST(SCR_RST1), .CYCLE_RST(CYC_RST1)) dut_w (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush), .mul_stall(mul_stall),
    .csr_en(csr_en), .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_rs1_idx(csr_rs1_idx),
    .csr_rs1_data(csr_rs1_data), .inst_cnt_data(inst_cnt_data),
    .inst_nop(o_nop[1]), .inst_r_en(o_ren[1]), .inst_r_pos(o_pos[1]),
    .csr_rdata(o_rdata[1]), .csr_rvalid(o_rvalid[1]), .csr_illegal(o_ill[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 unmapped, 1 cycle lo, 2 cycle hi, 3 instret lo, 4 instret hi, 5 mscratch
  function automatic int addr_kind(input logic [11:0] a);
    if (a inside {12'hC00, 12'hB00}) return 1;
    if (a inside {12'hC80, 12'hB80}) return 2;
    if (a inside {12'hC02, 12'hB02}) return 3;
    if (a inside {12'hC82, 12'hB82}) return 4;
    if (a == 12'h340) return 5;
    return 0;
  endfunction

  function automatic logic [63:0] cyc_of(input int k);
    return (k == 0) ? m_cyc : m_cyc + CYC_RST1;
  endfunction

  task automatic model_reset();
    m_cyc = 64'd0;
    m_scr[0] = 32'h0;
    m_scr[1] = SCR_RST1;
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = 32'h0;
      m_rv[k] = 1'b0;
      m_il[k] = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".rdata"}, {32'd0, o_rdata[k]}, {32'd0, m_rd[k]});
      chk({tag, ".rvalid"}, {63'd0, o_rvalid[k]}, {63'd0, m_rv[k]});
      chk({tag, ".illegal"}, {63'd0, o_ill[k]}, {63'd0, m_il[k]});
    end
  endtask

  // Apply one EX-stage cycle, check combinational outputs, clock, check registers.
  task automatic step(input logic v, input logic f, input logic st, input logic en,
                      input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                      input logic [31:0] d);
    logic live, acc, ill, wr, fok;
    int kd;
    logic [31:0] src, old, nv;
    logic [63:0] cv;
    ex_valid = v; flush = f; mul_stall = st; csr_en = en;
    csr_funct3 = f3; csr_addr = a; csr_rs1_idx = idx; csr_rs1_data = d;
    inst_cnt_data = $urandom();
    #1;
    live = v & ~f;
    acc  = en & live;
    kd   = addr_kind(a);
    for (int k = 0; k < 2; k++) begin
      chk("inst_nop", {63'd0, o_nop[k]}, {63'd0, live});
      chk("inst_r_en", {63'd0, o_ren[k]}, {63'd0, acc & (kd == 3 || kd == 4)});
      chk("inst_r_pos", {63'd0, o_pos[k]}, {63'd0, a[7]});
    end
    fok = (f3 != 3'd0) && (f3 != 3'd4);
    wr  = (f3 == 3'd1) || (f3 == 3'd5) || (idx != 5'd0);
    src = f3[2] ? {27'd0, idx} : d;
    ill = !fok || (kd == 0) || (wr && kd != 5);
    for (int k = 0; k < 2; k++) begin
      cv = cyc_of(k);
      case (kd)
        1: old = cv[31:0];
        2: old = cv[63:32];
        3, 4: old = inst_cnt_data;
        5: old = m_scr[k];
        default: old = 32'h0;
      endcase
      if (!st) begin
        if (acc && !ill) begin
          m_rd[k] = old;
          m_rv[k] = 1'b1;
          if (wr) begin
            case (f3[1:0])
              2'd1: nv = src;
              2'd2: nv = old | src;
              default: nv = old & ~src;
            endcase
            m_scr[k] = nv;
          end
        end else begin
          m_rv[k] = 1'b0;
        end
        m_il[k] = acc && ill;
      end
    end
    @(posedge clk);
    #1;
    m_cyc = m_cyc + 64'd1;
    check_regs("step");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 5'd0, 32'd0);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, a, 5'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    addr_tbl = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB00,
                 12'hB80, 12'hB02, 12'hB82, 12'h340, 12'h7C0};
    model_reset();
    repeat (2) @(negedge clk);
    check_regs("por");
    rst_n = 1'b1;

    // mcycle reads 10 after ten idle cycles
    repeat (10) idle();
    rd(12'hC00);
    chk("cycle_after_10", {32'd0, o_rdata[0]}, 64'd10);
    chk("cycle_valid", {63'd0, o_rvalid[0]}, 64'd1);

    // mscratch write / read-back / clear-immediate
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF);
    chk("csrrw_old", {32'd0, o_rdata[0]}, 64'h0);
    rd(12'h340);
    chk("scratch_new", {32'd0, o_rdata[0]}, 64'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 12'h340, 5'h0F, 32'h0);
    rd(12'h340);
    chk("scratch_rci", {32'd0, o_rdata[0]}, 64'hDEAD_BEE0);

    // instret high read, then the same read flushed
    rd(12'hC82);
    rd(12'hC82);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 12'hC82, 5'd0, 32'd0);
    chk("flush_rvalid", {63'd0, o_rvalid[0]}, 64'd0);

    // illegal: write to counter, unmapped read
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 12'hC00, 5'd1, 32'h5555_5555);
    chk("wr_counter_ill", {63'd0, o_ill[0]}, 64'd1);
    chk("wr_counter_rv", {63'd0, o_rvalid[0]}, 64'd0);
    rd(12'h7C0);
    chk("unmapped_ill", {63'd0, o_ill[0]}, 64'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 12'h340, 5'd0, 32'd0);

    // mcycle wrap on the near-wrap instance
    pulse_reset();
    idle();
    rd(12'hC00);
    chk("wrap_lo", {32'd0, o_rdata[1]}, 64'hFFFF_FFFF);
    rd(12'hC80);
    chk("wrap_hi", {32'd0, o_rdata[1]}, 64'h0);

    // CSRRW held by mul_stall for three cycles, single commit at release
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 12'h340, 5'd2, 32'hA5A5_0001);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 12'h340, 5'd2, 32'h0BAD_F00D);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 12'h340, 5'd2, 32'h0BAD_F00D);
    chk("stall_release_old", {32'd0, o_rdata[0]}, 64'hA5A5_0001);
    rd(12'h340);
    chk("stall_commit", {32'd0, o_rdata[0]}, 64'h0BAD_F00D);

    // reset pulsed in the middle of a stalled write
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 12'h340, 5'd2, 32'h7777_7777);
    pulse_reset();
    rd(12'h340);
    chk("scratch_after_rst", {32'd0, o_rdata[0]}, 64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic st, fl, v;
      logic [11:0] a;
      logic [4:0] idx;
      st  = ($urandom_range(0, 4) == 0);
      fl  = st ? 1'b0 : ($urandom_range(0, 7) == 0);
      v   = ($urandom_range(0, 9) != 0);
      a   = ($urandom_range(0, 9) == 0) ? 12'($urandom()) : addr_tbl[$urandom_range(0, 9)];
      idx = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom());
      step(v, fl, st, ($urandom_range(0, 3) != 0), 3'($urandom()), a, idx, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
